// File: rtl/frogger_pkg.sv
// Shared constants and types for the frog position controller.
package frogger_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned FROG_W   = 17;
  localparam int unsigned FROG_H   = 16;

  // USB HID keycodes for the WASD cluster.
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHop  = 2'd1,
    StHold = 2'd2
  } frog_state_t;

  function automatic logic key_valid(input logic [7:0] code);
    return (code == KEY_W) || (code == KEY_S) || (code == KEY_A) || (code == KEY_D);
  endfunction

  // Unmapped codes decode to up; callers qualify with key_valid.
  function automatic dir_t key_dir(input logic [7:0] code);
    case (code)
      KEY_S:   return DirDown;
      KEY_A:   return DirLeft;
      KEY_D:   return DirRight;
      default: return DirUp;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync-derived frame level into the pixel clock domain and emits a
// one-cycle tick three clocks after each rising edge.
module frame_tick_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_clk_i,
  output logic tick_o
);

  logic [2:0] sync_q;
  logic       tick_q;

  // Two synchroniser flops, one delay flop for edge detection, registered tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk_i};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/frog_motion.sv
// Frog position controller: one grid hop per key press, clamped to the
// playfield, with respawn on death or on reaching the home row.
// Build option: define FROG_SMOOTH_HOP_EN to animate each hop over HOP_FRAMES
// frame ticks; otherwise the whole hop is applied on a single tick.
module frog_motion
  import frogger_pkg::*;
#(
  parameter int unsigned STEP       = 16,
  parameter int unsigned START_X    = 312,
  parameter int unsigned START_Y    = 464,
  parameter int unsigned HOP_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       death,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [1:0] dir,
  output logic       hopping,
  output logic       home
);

  localparam logic [9:0] StepPx = 10'(STEP);
  localparam logic [9:0] XMax   = 10'(SCREEN_W - FROG_W);
  localparam logic [9:0] YMax   = 10'(SCREEN_H - FROG_H);
  localparam logic [9:0] StartX = 10'(START_X);
  localparam logic [9:0] StartY = 10'(START_Y);
`ifdef FROG_SMOOTH_HOP_EN
  localparam logic [9:0] StepAmt = 10'(STEP / HOP_FRAMES);
`else
  // Equals STEP, since STEP is a whole multiple of HOP_FRAMES.
  localparam logic [9:0] StepAmt = 10'((STEP / HOP_FRAMES) * HOP_FRAMES);
`endif

  logic        tick;
  frog_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  dir_t        dir_q, dir_d;
  logic        hopping_q, hopping_d;
  logic        home_q, home_d;
  logic        dead_q, dead_d;
  logic        respawn_q, respawn_d;
`ifdef FROG_SMOOTH_HOP_EN
  logic [2:0]  cnt_q, cnt_d;
`endif

  logic        key_ok;
  dir_t        mv_dir;
  logic [9:0]  moved_x, moved_y;
  logic        legal;

  frame_tick_sync u_sync (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .frame_clk_i (frame_clk),
    .tick_o      (tick)
  );

  assign key_ok = key_valid(keycode);
  // A hop in flight keeps its latched direction; otherwise the key picks it.
  assign mv_dir = (state_q == StHop) ? dir_q : key_dir(keycode);

  // Candidate position one move away, and whether a full STEP fits that way.
  always_comb begin
    moved_x = x_q;
    moved_y = y_q;
    legal   = 1'b0;
    case (mv_dir)
      DirUp: begin
        moved_y = y_q - StepAmt;
        legal   = (y_q >= StepPx);
      end
      DirDown: begin
        moved_y = y_q + StepAmt;
        legal   = (y_q <= YMax - StepPx);
      end
      DirLeft: begin
        moved_x = x_q - StepAmt;
        legal   = (x_q >= StepPx);
      end
      default: begin
        moved_x = x_q + StepAmt;
        legal   = (x_q <= XMax - StepPx);
      end
    endcase
  end

  // Next-state: respawn beats hop progress, which beats a new key press.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    hopping_d = hopping_q;
    home_d    = 1'b0;
    dead_d    = dead_q | death;
    respawn_d = respawn_q;
`ifdef FROG_SMOOTH_HOP_EN
    cnt_d     = cnt_q;
`endif
    if (tick) begin
      if (dead_q || death || respawn_q) begin
        x_d       = StartX;
        y_d       = StartY;
        if (dead_q || death) dir_d = DirUp;
        hopping_d = 1'b0;
        state_d   = StHold;
        dead_d    = 1'b0;
        respawn_d = 1'b0;
`ifdef FROG_SMOOTH_HOP_EN
        cnt_d     = '0;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            if (key_ok) begin
              dir_d = mv_dir;
              if (legal) begin
                x_d       = moved_x;
                y_d       = moved_y;
                hopping_d = 1'b1;
`ifdef FROG_SMOOTH_HOP_EN
                state_d   = StHop;
                cnt_d     = 3'd1;
`else
                state_d   = StHold;
                if (moved_y == '0) begin
                  home_d    = 1'b1;
                  respawn_d = 1'b1;
                end
`endif
              end else begin
                state_d = StHold;
              end
            end
          end
`ifdef FROG_SMOOTH_HOP_EN
          StHop: begin
            x_d = moved_x;
            y_d = moved_y;
            if (cnt_q == 3'(HOP_FRAMES - 1)) begin
              state_d   = StHold;
              hopping_d = 1'b0;
              cnt_d     = '0;
              if (moved_y == '0) begin
                home_d    = 1'b1;
                respawn_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
`endif
          StHold: begin
            hopping_d = 1'b0;
            if (!key_ok) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // State and output registers; Reset clears everything asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      x_q       <= StartX;
      y_q       <= StartY;
      dir_q     <= DirUp;
      hopping_q <= 1'b0;
      home_q    <= 1'b0;
      dead_q    <= 1'b0;
      respawn_q <= 1'b0;
`ifdef FROG_SMOOTH_HOP_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      hopping_q <= hopping_d;
      home_q    <= home_d;
      dead_q    <= dead_d;
      respawn_q <= respawn_d;
`ifdef FROG_SMOOTH_HOP_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign BallX   = x_q;
  assign BallY   = y_q;
  assign dir     = dir_q;
  assign hopping = hopping_q;
  assign home    = home_q;

endmodule
